// File: rtl/vc_ring_pkg.sv
// Shared width helpers and the VC identifier type for the virtual-channel ring FIFO.
package vc_ring_pkg;

  localparam int VC_ID_MAX_W = 8;

  typedef logic [VC_ID_MAX_W-1:0] vc_id_t;

  function automatic int vcIdWidth(input int numVc);
    if (numVc > 1) begin
      return $clog2(numVc);
    end else begin
      return 1;
    end
  endfunction

  // Wrap-bit pointers and occupancy both need one bit beyond the index width.
  function automatic int occWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vc_fifo_lane.sv
// One virtual channel: circular buffer with wrap-bit pointers, first-word
// fall-through head and occupancy flags derived purely from the pointers.
module vc_fifo_lane
  import vc_ring_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int AFUL_LVL = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wrEn,
  input  logic [WIDTH-1:0]             wrDat,
  input  logic                         rdEn,
  output logic [WIDTH-1:0]             rdDat,
  output logic                         notEmpty,
  output logic                         ful,
  output logic                         aFul,
  output logic [occWidth(DEPTH)-1:0]   cnt,
  output logic                         ovfHit,
  output logic                         udfHit
);

  localparam int PW = occWidth(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]    wrPtr_r;
  logic [PW-1:0]    rdPtr_r;
  logic [PW-1:0]    occ_s;
  logic             push_s;
  logic             pop_s;
  logic [WIDTH-1:0] mem_r [DEPTH];

  // Flags from registered pointers only; a full lane still accepts a write when it pops.
  always_comb begin
    occ_s    = wrPtr_r - rdPtr_r;
    cnt      = occ_s;
    notEmpty = (occ_s != '0);
    ful      = (occ_s == PW'(DEPTH));
    aFul     = (occ_s >= PW'(AFUL_LVL));
    pop_s    = rdEn & notEmpty;
    push_s   = wrEn & (~ful | rdEn);
    ovfHit   = wrEn & ful & ~rdEn;
    udfHit   = rdEn & ~notEmpty;
    if (notEmpty) begin
      rdDat = mem_r[rdPtr_r[AW-1:0]];
    end else begin
      rdDat = '0;
    end
  end

  // Pointer advance; reset empties the lane without touching storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_r <= '0;
      rdPtr_r <= '0;
    end else begin
      if (push_s) begin
        wrPtr_r <= wrPtr_r + PW'(1);
      end
      if (pop_s) begin
        rdPtr_r <= rdPtr_r + PW'(1);
      end
    end
  end

  // Storage write at the tail slot.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wrPtr_r[AW-1:0]] <= wrDat;
    end
  end

endmodule

// File: rtl/vc_ring_fifo.sv
// Multi-VC FIFO: demultiplexes writes onto per-VC lanes and collects
// sticky overflow/underflow indications.
module vc_ring_fifo
  import vc_ring_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int NUM_VC   = 2,
  parameter int AFUL_LVL = DEPTH - 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     iWrEn,
  input  logic [vcIdWidth(NUM_VC)-1:0]             iWrVc,
  input  logic [WIDTH-1:0]                         iWrDat,
  input  logic [NUM_VC-1:0]                        iRdEn,
  output logic [NUM_VC-1:0][WIDTH-1:0]             oRdDat,
  output logic [NUM_VC-1:0]                        oNotEmpty,
  output logic [NUM_VC-1:0]                        oFul,
  output logic [NUM_VC-1:0]                        oAFul,
  output logic [NUM_VC-1:0][occWidth(DEPTH)-1:0]   oCnt,
  output logic                                     oOvf,
  output logic                                     oUdf
);

  vc_id_t            wrVc_s;
  logic [NUM_VC-1:0] laneWrEn_s;
  logic [NUM_VC-1:0] ovfHit_s;
  logic [NUM_VC-1:0] udfHit_s;

  // Write demux; an id beyond NUM_VC-1 selects no lane and is dropped.
  always_comb begin
    wrVc_s     = vc_id_t'(iWrVc);
    laneWrEn_s = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      laneWrEn_s[v] = iWrEn & (wrVc_s == vc_id_t'(v));
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : gLane
    vc_fifo_lane #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .AFUL_LVL(AFUL_LVL)
    ) uLane (
      .clk     (clk),
      .rst     (rst),
      .wrEn    (laneWrEn_s[v]),
      .wrDat   (iWrDat),
      .rdEn    (iRdEn[v]),
      .rdDat   (oRdDat[v]),
      .notEmpty(oNotEmpty[v]),
      .ful     (oFul[v]),
      .aFul    (oAFul[v]),
      .cnt     (oCnt[v]),
      .ovfHit  (ovfHit_s[v]),
      .udfHit  (udfHit_s[v])
    );
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oOvf <= 1'b0;
      oUdf <= 1'b0;
    end else begin
      oOvf <= oOvf | (|ovfHit_s);
      oUdf <= oUdf | (|udfHit_s);
    end
  end

endmodule
